// File: rtl/rv_mem_pkg.sv
// Shared constants and decode helper for the data-memory subsystem.
// Address map, CON_STAT bit layout and decode-target enum.
package rv_mem_pkg;

    localparam logic [31:0] MMIO_BASE    = 32'h8000_0000;
    localparam logic [3:0]  OFF_CON_TX   = 4'h0;
    localparam logic [3:0]  OFF_CON_STAT = 4'h4;
    localparam logic [3:0]  OFF_CYCLE    = 4'h8;

    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_CNT_LSB = 4;
    localparam int STAT_CNT_W   = 4;

    typedef enum logic [2:0] {
        RAM,
        CON_TX,
        CON_STAT,
        CYCLE,
        NONE
    } dec_t;

    function automatic dec_t decode(
        input logic       mmio,
        input logic [1:0] reg_sel
    );
        dec_t t;
        t = NONE;
        if (!mmio) begin
            t = RAM;
        end else begin
            case ({reg_sel, 2'b00})
                OFF_CON_TX:   t = CON_TX;
                OFF_CON_STAT: t = CON_STAT;
                OFF_CYCLE:    t = CYCLE;
                default:      t = NONE;
            endcase
        end
        return t;
    endfunction

endpackage

// File: rtl/rv_con_fifo.sv
// Console transmit FIFO: byte push, valid/ready pop, sticky overflow.
// A push while full is only accepted when the head pops in that cycle.
module rv_con_fifo
    import rv_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [7:0]                 push_data,
    input  logic                       ovf_clr,
    input  logic                       ready,
    output logic                       valid,
    output logic [7:0]                 data,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          pop;
    logic          wr_en;

    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(DEPTH));
    assign valid = !empty;
    assign data  = mem[rptr];
    assign pop   = valid && ready;
    assign wr_en = push && (!full || pop);

    // Storage is deliberately not reset; valid masks stale bytes.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !wr_en) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rv_dmem.sv
// Data memory: word RAM plus MMIO console FIFO and cycle counter.
// Optional counter enabled by defining RV_DMEM_CYCLE_CNT_EN.
module rv_dmem
    import rv_mem_pkg::*;
#(
    parameter int DPWIDTH    = 32,
    parameter int RAM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DPWIDTH-1:0] dmem_addr,
    input  logic [DPWIDTH-1:0] dmem_dataout,
    input  logic               memrw,
    output logic [DPWIDTH-1:0] dmem_datain,
    output logic               con_valid,
    output logic [7:0]         con_data,
    input  logic               con_ready
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    dec_t                 sel;
    logic [AW-1:0]        ram_idx;
    logic [DPWIDTH-1:0]   ram [RAM_WORDS];
    logic [DPWIDTH-1:0]   stat;
    logic [DPWIDTH-1:0]   cycle;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_ovf;
    logic [CW-1:0]        fifo_count;
    logic                 unused;

    assign sel     = decode(dmem_addr[DPWIDTH-1], dmem_addr[3:2]);
    assign ram_idx = dmem_addr[AW+1:2];
    assign unused  = ^{dmem_addr[DPWIDTH-2:AW+2], dmem_addr[1:0]};

    always_ff @(posedge clk) begin
        if (memrw && sel == RAM) begin
            ram[ram_idx] <= dmem_dataout;
        end
    end

    rv_con_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (memrw && sel == CON_TX),
        .push_data (dmem_dataout[7:0]),
        .ovf_clr   (memrw && sel == CON_STAT),
        .ready     (con_ready),
        .valid     (con_valid),
        .data      (con_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overflow  (fifo_ovf),
        .count     (fifo_count)
    );

`ifdef RV_DMEM_CYCLE_CNT_EN
    // A store to CYCLE wins over the free-running increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle <= '0;
        end else if (memrw && sel == CYCLE) begin
            cycle <= dmem_dataout;
        end else begin
            cycle <= cycle + 1'b1;
        end
    end
`else
    assign cycle = '0;
`endif

    always_comb begin
        stat                                = '0;
        stat[STAT_FULL]                     = fifo_full;
        stat[STAT_EMPTY]                    = fifo_empty;
        stat[STAT_OVF]                      = fifo_ovf;
        stat[STAT_CNT_LSB +: STAT_CNT_W]    = STAT_CNT_W'(fifo_count);
    end

    always_comb begin
        dmem_datain = '0;
        case (sel)
            RAM:      dmem_datain = ram[ram_idx];
            CON_STAT: dmem_datain = stat;
            CYCLE:    dmem_datain = cycle;
            default:  dmem_datain = '0;
        endcase
    end

endmodule

// File: tb/tb_rv_dmem.sv
// Randomised bench for rv_dmem against a queue/array reference model.
// Covers RAM aliasing, console FIFO rules, CON_STAT and CYCLE.
module tb_rv_dmem;

`ifdef RV_DMEM_CYCLE_CNT_EN
    localparam bit CYC_EN = 1'b1;
`else
    localparam bit CYC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_dataout;
    logic        memrw;
    logic [31:0] dmem_datain;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready;

    always #5 clk = ~clk;

    rv_dmem dut (
        .clk          (clk),
        .rst          (rst),
        .dmem_addr    (dmem_addr),
        .dmem_dataout (dmem_dataout),
        .memrw        (memrw),
        .dmem_datain  (dmem_datain),
        .con_valid    (con_valid),
        .con_data     (con_data),
        .con_ready    (con_ready)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] m_ram [int unsigned];
    logic [7:0]  m_q [$];
    bit          m_ovf;
    logic [31:0] m_cyc;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] s;
        s = '0;
        if (!a[31]) return m_ram[int'(a[11:2])];
        case (a[3:2])
            2'd1: begin
                s[0]   = (m_q.size() == 4);
                s[1]   = (m_q.size() == 0);
                s[2]   = m_ovf;
                s[7:4] = 4'(m_q.size());
                return s;
            end
            2'd2:    return CYC_EN ? m_cyc : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    // One bus cycle: drive, check combinational outputs, then advance model.
    task automatic op(input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic rdy,
                      input string tag);
        bit pop;
        @(negedge clk);
        memrw        = wr;
        dmem_addr    = a;
        dmem_dataout = d;
        con_ready    = rdy;
        #1;
        if (a[31] || m_ram.exists(int'(a[11:2])))
            check(tag, dmem_datain, m_read(a));
        check("con_valid", {31'b0, con_valid}, {31'b0, m_q.size() != 0});
        if (m_q.size() != 0)
            check("con_data", {24'b0, con_data}, {24'b0, m_q[0]});
        @(posedge clk);
        pop = (m_q.size() != 0) && rdy;
        if (pop) void'(m_q.pop_front());
        if (wr && a[31] && a[3:2] == 2'd0) begin
            if (m_q.size() < 4) m_q.push_back(d[7:0]);
            else m_ovf = 1'b1;
        end
        if (wr && a[31] && a[3:2] == 2'd1) m_ovf = 1'b0;
        if (wr && a[31] && a[3:2] == 2'd2) m_cyc = d;
        else m_cyc = m_cyc + 1;
        if (wr && !a[31]) m_ram[int'(a[11:2])] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        memrw     = 1'b0;
        con_ready = 1'b0;
        dmem_addr = 32'h8000_0000;
        @(posedge clk);
        m_q.delete();
        m_ovf = 1'b0;
        m_cyc = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_valid", {31'b0, con_valid}, 32'h0);
        check("rst_contx", dmem_datain, 32'h0);
        @(posedge clk);
        m_cyc = m_cyc + 1;
    endtask

    localparam logic [31:0] TX   = 32'h8000_0000;
    localparam logic [31:0] STAT = 32'h8000_0004;
    localparam logic [31:0] CYC  = 32'h8000_0008;
    localparam logic [31:0] RSV  = 32'h8000_000C;

    initial begin
        int          kind;
        logic        rdy;
        logic        wr;
        logic [31:0] a;
        rst          = 1'b1;
        memrw        = 1'b0;
        con_ready    = 1'b0;
        dmem_addr    = '0;
        dmem_dataout = '0;

        do_reset();
        for (int i = 0; i < 9; i++) op(0, RSV, 0, 0, "idle");
        op(0, CYC, 0, 0, "cycle10");

        op(1, 32'h0000_0010, 32'hDEAD_BEEF, 0, "ram_wr");
        op(0, 32'h0000_0010, 0, 0, "ram_rd");
        op(0, 32'h0000_1010, 0, 0, "ram_alias");

        for (int i = 0; i < 5; i++) op(1, TX, 32'h41 + i, 0, "push");
        op(0, STAT, 0, 0, "stat_full_ovf");
        for (int i = 0; i < 5; i++) op(0, RSV, 0, 1, "drain");
        op(0, STAT, 0, 0, "stat_empty");

        op(1, STAT, 0, 0, "ovf_clr");
        op(0, STAT, 0, 0, "stat_cleared");

        for (int i = 0; i < 4; i++) op(1, TX, 32'h61 + i, 0, "fill");
        op(1, TX, 32'h70, 1, "push_pop_full");
        op(0, STAT, 0, 0, "stat_pp");
        for (int i = 0; i < 5; i++) op(0, RSV, 0, 1, "drain2");

        op(1, CYC, 32'hFFFF_FFFE, 0, "cyc_wr");
        op(0, CYC, 0, 0, "cyc_fffe");
        op(0, CYC, 0, 0, "cyc_ffff");
        op(0, CYC, 0, 0, "cyc_wrap");
        op(1, RSV, 32'h1234, 0, "rsv_wr");
        op(0, RSV, 0, 0, "rsv_rd");

        for (int i = 0; i < 3; i++) op(1, TX, 32'h30 + i, 0, "preq");
        do_reset();
        op(0, STAT, 0, 0, "stat_after_rst");
        op(0, 32'h0000_0010, 0, 0, "ram_kept");

        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 7);
            rdy  = 1'($urandom);
            wr   = 1'b0;
            if (kind < 4) begin
                a  = {1'b0, 19'($urandom), 6'b0,
                      4'($urandom_range(0, 15)), 2'($urandom)};
                wr = (kind < 2);
            end else begin
                a = {1'b1, 27'($urandom), 2'(kind - 4), 2'($urandom)};
                case (kind)
                    4:       wr = ($urandom_range(0, 2) != 0);
                    6:       wr = ($urandom_range(0, 9) == 0);
                    default: wr = 1'($urandom);
                endcase
            end
            op(wr, a, $urandom, rdy, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
